linebuffer_ctrl: RTL

Sequencer for the 63-entry, 8-bit `linebuffer` storage block. On `start` it processes an image row by row:
- fill the line buffer with one row read from the image ROM;
- drain that row out in mirrored (right-to-left) order over a valid/ready stream.

It sits between the image ROM, the line buffer and the downstream pixel consumer, and owns all line-buffer index, write and read strobes.

---
 rtl/linebuffer_pkg.sv | 16 +
 rtl/linebuffer_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/linebuffer_pkg.sv
// Shared types and sizes for the line-buffer sequencer and its storage block.
package linebuffer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } lbc_state_t;

  localparam int LB_DEPTH   = 63;
  localparam int LB_IDX_W   = 6;
  localparam int LB_DATA_W  = 8;
  localparam int ROM_ADDR_W = 12;

endpackage

// File: rtl/linebuffer_ctrl.sv
// Row sequencer: fills the line buffer from the image ROM, then streams the
// row back out right-to-left over a valid/ready interface.
module linebuffer_ctrl
  import linebuffer_pkg::*;
#(
  parameter int LINE_LEN = LB_DEPTH,
  parameter int ROWS     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_rd,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [LB_DATA_W-1:0]  rom_data,
  output logic [LB_IDX_W-1:0]   lb_index,
  output logic                  lb_we,
  output logic [LB_DATA_W-1:0]  lb_wdata,
  output logic                  lb_re,
  input  logic [LB_DATA_W-1:0]  lb_rdata,
  output logic                  out_valid,
  output logic [LB_DATA_W-1:0]  out_data,
  input  logic                  out_ready
);

  localparam logic [LB_IDX_W-1:0]   LEN      = LB_IDX_W'(LINE_LEN);
  localparam logic [LB_IDX_W-1:0]   LAST     = LB_IDX_W'(LINE_LEN - 1);
  localparam logic [LB_IDX_W-1:0]   ONE_IDX  = LB_IDX_W'(1);
  localparam logic [ROM_ADDR_W-1:0] ROW_LAST = ROM_ADDR_W'(ROWS - 1);
  localparam logic [ROM_ADDR_W-1:0] ONE_ROW  = ROM_ADDR_W'(1);
  localparam logic [ROM_ADDR_W-1:0] ROW_STEP = ROM_ADDR_W'(LINE_LEN);

  lbc_state_t             state_q, state_d;
  logic [ROM_ADDR_W-1:0]  row_q, row_d;
  logic [ROM_ADDR_W-1:0]  base_q, base_d;
  logic [LB_IDX_W-1:0]    k_q, k_d;
  logic [LB_IDX_W-1:0]    lc_q, lc_d;
  logic [LB_IDX_W-1:0]    tc_q, tc_d;
  logic                   vld_q, vld_d;
  logic [LB_DATA_W-1:0]   data_q, data_d;
  // Low for the first edge after reset release so a start there is dropped.
  logic                   arm_q;
  logic                   load;
  logic                   xfer;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      base_q  <= '0;
      k_q     <= '0;
      lc_q    <= '0;
      tc_q    <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      base_q  <= base_d;
      k_q     <= k_d;
      lc_q    <= lc_d;
      tc_q    <= tc_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      arm_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    base_d   = base_q;
    k_d      = k_q;
    lc_d     = lc_q;
    tc_d     = tc_q;
    vld_d    = vld_q;
    data_d   = data_q;
    rom_rd   = 1'b0;
    rom_addr = '0;
    lb_index = '0;
    lb_we    = 1'b0;
    lb_wdata = '0;
    lb_re    = 1'b0;
    load     = 1'b0;
    xfer     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && arm_q) begin
          state_d = FILL;
          row_d   = '0;
          base_d  = '0;
          k_d     = '0;
        end
      end

      FILL: begin
        if (k_q < LEN) begin
          rom_rd   = 1'b1;
          rom_addr = base_q + ROM_ADDR_W'(k_q);
        end
        // ROM data lags its read by one cycle, so writes trail reads by one.
        if (k_q != '0) begin
          lb_we    = 1'b1;
          lb_index = k_q - ONE_IDX;
          lb_wdata = rom_data;
        end
        if (k_q == LEN) begin
          state_d = DRAIN;
          k_d     = '0;
          lc_d    = '0;
          tc_d    = '0;
        end else begin
          k_d = k_q + ONE_IDX;
        end
      end

      DRAIN: begin
        load = (lc_q < LEN) && (!vld_q || out_ready);
        xfer = vld_q && out_ready;
        if (lc_q < LEN) lb_index = LAST - lc_q;
        if (load) begin
          lb_re  = 1'b1;
          data_d = lb_rdata;
          vld_d  = 1'b1;
          lc_d   = lc_q + ONE_IDX;
        end else if (out_ready) begin
          vld_d = 1'b0;
        end
        if (xfer) begin
          tc_d = tc_q + ONE_IDX;
          if (tc_q == LAST) begin
            if (row_q == ROW_LAST) begin
              state_d = DONE;
            end else begin
              state_d = FILL;
              row_d   = row_q + ONE_ROW;
              base_d  = base_q + ROW_STEP;
              k_d     = '0;
            end
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_valid = vld_q;
  assign out_data  = data_q;

endmodule
